// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue slice: FSM states, request classes,
// ALU op codes and condition codes, plus the condition evaluator.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_CMP   = 2'b10;
  localparam logic [1:0] CLS_MEM   = 2'b11;

  // The ALU op code is the request class itself.
  localparam logic [1:0] OP_ARITH = CLS_ARITH;
  localparam logic [1:0] OP_LOGIC = CLS_LOGIC;
  localparam logic [1:0] OP_CMP   = CLS_CMP;
  localparam logic [1:0] OP_MEM   = CLS_MEM;

  localparam logic [1:0] COND_ALWAYS  = 2'b00;
  localparam logic [1:0] COND_C       = 2'b01;
  localparam logic [1:0] COND_Z       = 2'b10;
  localparam logic [1:0] COND_ALWAYS2 = 2'b11;

  function automatic logic cond_pass(input logic [1:0] cond, input logic c, input logic z);
    logic pass;
    case (cond)
      COND_ALWAYS:  pass = 1'b1;
      COND_C:       pass = c;
      COND_Z:       pass = z;
      COND_ALWAYS2: pass = 1'b1;
      default:      pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/alu_issue.sv
// Issue controller: accepts one conditional request, drives an external ALU
// for a single EXEC cycle, updates C/Z and emits a one-cycle completion record.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_cls,
  input  logic [1:0]    req_cond,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic [RW-1:0] req_rd,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic [1:0]    alu_flags,
  output logic          done,
  output logic [DW-1:0] done_data,
  output logic [RW-1:0] done_rd,
  output logic          done_wr,
  output logic          done_br,
  output logic          done_addr,
  output logic          flag_c,
  output logic          flag_z
);

  state_e        state_q, state_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_z_q, flag_z_d;
  logic          done_q, done_d;
  logic [DW-1:0] done_data_q, done_data_d;
  logic [RW-1:0] done_rd_q, done_rd_d;
  logic          done_wr_q, done_wr_d;
  logic          done_br_q, done_br_d;
  logic          done_addr_q, done_addr_d;
  logic          pass_s;
  logic          zero_s;
  logic          unused_zflag_s;

  // Z comes from the result itself; the ALU's own zero flag is ignored.
  assign zero_s         = (alu_result == {DW{1'b0}});
  assign pass_s         = cond_pass(req_cond, flag_c_q, flag_z_q);
  assign unused_zflag_s = alu_flags[0];

  // State register and all datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_op_q    <= 2'b00;
      alu_a_q     <= {DW{1'b0}};
      alu_b_q     <= {DW{1'b0}};
      rd_q        <= {RW{1'b0}};
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      done_q      <= 1'b0;
      done_data_q <= {DW{1'b0}};
      done_rd_q   <= {RW{1'b0}};
      done_wr_q   <= 1'b0;
      done_br_q   <= 1'b0;
      done_addr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rd_q        <= rd_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      done_rd_q   <= done_rd_d;
      done_wr_q   <= done_wr_d;
      done_br_q   <= done_br_d;
      done_addr_q <= done_addr_d;
    end
  end

  // Next-state logic; a failed condition skips EXEC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = pass_s ? S_EXEC : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: ALU drive is live only in EXEC, completion record only in DONE.
  always_comb begin
    alu_op_d    = 2'b00;
    alu_a_d     = {DW{1'b0}};
    alu_b_d     = {DW{1'b0}};
    rd_d        = rd_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    done_d      = 1'b0;
    done_data_d = {DW{1'b0}};
    done_rd_d   = {RW{1'b0}};
    done_wr_d   = 1'b0;
    done_br_d   = 1'b0;
    done_addr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rd_d = req_rd;
          if (pass_s) begin
            alu_op_d = req_cls;
            alu_a_d  = req_a;
            alu_b_d  = req_b;
          end else begin
            done_d    = 1'b1;
            done_rd_d = req_rd;
          end
        end else begin
          rd_d = rd_q;
        end
      end
      S_EXEC: begin
        done_d      = 1'b1;
        done_rd_d   = rd_q;
        done_data_d = alu_result;
        case (alu_op_q)
          OP_ARITH: begin
            done_wr_d = 1'b1;
            flag_c_d  = alu_flags[1];
            flag_z_d  = zero_s;
          end
          OP_LOGIC: begin
            done_wr_d = 1'b1;
            flag_z_d  = zero_s;
          end
          OP_CMP:  done_br_d   = zero_s;
          OP_MEM:  done_addr_d = 1'b1;
          default: done_wr_d   = 1'b0;
        endcase
      end
      S_DONE:  done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  // Output decode.
  always_comb begin
    req_ready = (state_q == S_IDLE);
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign done      = done_q;
  assign done_data = done_data_q;
  assign done_rd   = done_rd_q;
  assign done_wr   = done_wr_q;
  assign done_br   = done_br_q;
  assign done_addr = done_addr_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU beside the DUT, integer reference model
// of flags and completion records, directed cases then randomized requests.
module tb_alu_issue;
  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_cls = 2'b00;
  logic [1:0]    req_cond = 2'b00;
  logic [DW-1:0] req_a = 16'h0000;
  logic [DW-1:0] req_b = 16'h0000;
  logic [RW-1:0] req_rd = 3'd0;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [1:0]    alu_flags;
  logic          done, done_wr, done_br, done_addr, flag_c, flag_z;
  logic [DW-1:0] done_data;
  logic [RW-1:0] done_rd;
  logic          junk_r = 1'b0;

  int checks = 0;
  int errors = 0;
  bit m_c = 1'b0;
  bit m_z = 1'b0;

  alu_issue #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cls(req_cls), .req_cond(req_cond), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .done(done), .done_data(done_data), .done_rd(done_rd), .done_wr(done_wr),
    .done_br(done_br), .done_addr(done_addr), .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: add / xor / subtract / add; bit 0 of the flags is noise.
  always_comb begin
    logic [16:0] t;
    t = 17'd0;
    case (alu_op)
      2'b00:   t = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   t = {junk_r, alu_a ^ alu_b};
      2'b10:   t = {1'b0, alu_a} - {1'b0, alu_b};
      default: t = {1'b0, alu_a} + {1'b0, alu_b};
    endcase
    alu_result = t[15:0];
    alu_flags  = {t[16], junk_r};
  end

  always @(negedge clk) junk_r <= 1'($urandom_range(0, 1));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] cls, input logic [1:0] cond,
                       input logic [15:0] a, input logic [15:0] b, input logic [2:0] rd);
    bit pass, ex_wr, ex_br, ex_ad, seen;
    int sum, res, n;
    @(negedge clk);
    check_eq("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_cls = cls; req_cond = cond; req_a = a; req_b = b; req_rd = rd;
    pass = (cond == 2'b00) || (cond == 2'b11) || (cond == 2'b01 && m_c) || (cond == 2'b10 && m_z);
    ex_wr = 0; ex_br = 0; ex_ad = 0; res = 0;
    if (pass) begin
      case (cls)
        2'b00: begin
          sum = int'(a) + int'(b); res = sum % 65536;
          m_c = (sum >= 65536); m_z = (res == 0); ex_wr = 1;
        end
        2'b01: begin res = int'(a ^ b); m_z = (res == 0); ex_wr = 1; end
        2'b10: begin res = (int'(a) - int'(b) + 65536) % 65536; ex_br = (a == b); end
        default: begin res = (int'(a) + int'(b)) % 65536; ex_ad = 1; end
      endcase
    end
    @(posedge clk);
    #1;
    // Garbage offered while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_cls = 2'($urandom); req_cond = 2'($urandom);
    req_a = 16'($urandom); req_b = 16'($urandom); req_rd = 3'($urandom);
    seen = 0; n = 0;
    while (!seen && n < 5) begin
      @(negedge clk);
      n++;
      if (pass && n == 1) begin
        check_eq("exec_op", alu_op, cls);
        check_eq("exec_a", alu_a, a);
        check_eq("exec_b", alu_b, b);
        check_eq("exec_no_done", done, 0);
      end
      if (done) seen = 1;
    end
    req_valid = 1'b0;
    check_eq("done_seen", seen, 1);
    if (seen) begin
      check_eq("latency", n, pass ? 2 : 1);
      check_eq("done_data", done_data, res);
      check_eq("done_rd", done_rd, rd);
      check_eq("done_wr", done_wr, ex_wr);
      check_eq("done_br", done_br, ex_br);
      check_eq("done_addr", done_addr, ex_ad);
      check_eq("alu_idle", {alu_op, alu_a, alu_b}, 0);
      check_eq("flag_c", flag_c, m_c);
      check_eq("flag_z", flag_z, m_z);
    end
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("rec_zero", {done_data, done_rd, done_wr, done_br, done_addr}, 0);
    check_eq("ready_back", req_ready, 1);
  endtask

  initial begin
    #2;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_flags", {flag_c, flag_z}, 0);
    check_eq("rst_alu", {alu_op, alu_a, alu_b}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", req_ready, 1);

    issue(2'b00, 2'b00, 16'h0003, 16'h0003, 3'd1);
    issue(2'b00, 2'b00, 16'hFFFF, 16'h0001, 3'd2);
    issue(2'b00, 2'b01, 16'h0002, 16'h0005, 3'd3);
    issue(2'b00, 2'b10, 16'h0004, 16'h0004, 3'd4);
    issue(2'b10, 2'b00, 16'h0003, 16'h0003, 3'd5);
    issue(2'b10, 2'b11, 16'h0003, 16'h0004, 3'd6);
    issue(2'b00, 2'b00, 16'hFFFF, 16'h0001, 3'd7);
    issue(2'b01, 2'b00, 16'hFFFF, 16'hFFFF, 3'd0);
    issue(2'b11, 2'b00, 16'h0010, 16'h0004, 3'd1);

    // Reset in the middle of an executing request.
    @(negedge clk);
    req_valid = 1'b1; req_cls = 2'b00; req_cond = 2'b00; req_a = 16'h0005; req_b = 16'h0006; req_rd = 3'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_exec_a", alu_a, 16'h0005);
    rst = 1'b1;
    #1;
    check_eq("rst_now_done", done, 0);
    check_eq("rst_now_alu", {alu_op, alu_a, alu_b}, 0);
    check_eq("rst_now_flags", {flag_c, flag_z}, 0);
    check_eq("rst_now_ready", req_ready, 1);
    m_c = 1'b0; m_z = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check_eq("rel_no_done", done, 0);
      @(negedge clk);
    end

    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra, rb;
      ra = (i % 7 == 0) ? 16'hFFFF : 16'($urandom);
      rb = (i % 5 == 0) ? ra : 16'($urandom);
      if (i % 11 == 0) rb = 16'(17'h10000 - {1'b0, ra});
      issue(2'($urandom), 2'($urandom), ra, rb, 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
